// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, the hazard scoreboard
// entry and the opcode constants also used by the control unit.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] OP_LW     = 5'b00000;
  localparam logic [4:0] OP_SW     = 5'b01000;
  localparam logic [4:0] OP_ADDI   = 5'b00100;
  localparam logic [4:0] OP_RTYPE  = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // Source fields are only meaningful in the EX entry; MEM/WB carry them along unused.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memtoreg;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // x0 is hardwired, so an entry targeting it never produces a value worth tracking.
  function automatic logic is_writer(input sb_entry_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

  function automatic logic src_hit(input logic use1, input logic [REG_W-1:0] rs1,
                                   input logic use2, input logic [REG_W-1:0] rs2,
                                   input sb_entry_t e);
    return is_writer(e) && ((use1 && (rs1 == e.rd)) || (use2 && (rs2 == e.rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; frozen while hold is high.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !hold && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: shadow scoreboard of EX/MEM/WB destinations,
// load-use stalls, MEM-stage redirect flushes and EX operand forwarding selects.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             mem_redirect,
  input  logic             ext_hold,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  sb_entry_t id_e;
  logic      haz_ex, haz_mem, haz_wb, stall_raw, stall;
  logic      stall_evt, flush_evt;

  always_comb begin
    id_e          = SB_BUBBLE;
    id_e.valid    = id_valid;
    id_e.rd       = id_rd;
    id_e.regwrite = id_regwrite;
    id_e.memtoreg = id_memtoreg;
    id_e.rs1      = id_rs1;
    id_e.rs2      = id_rs2;
    id_e.use_rs1  = id_use_rs1;
    id_e.use_rs2  = id_use_rs2;
  end

  assign haz_ex  = src_hit(id_use_rs1, id_rs1, id_use_rs2, id_rs2, ex_q);
  assign haz_mem = src_hit(id_use_rs1, id_rs1, id_use_rs2, id_rs2, mem_q);
  assign haz_wb  = src_hit(id_use_rs1, id_rs1, id_use_rs2, id_rs2, wb_q);

  // With forwarding only a load still in EX is too late; without it every older writer blocks.
  assign stall_raw = (FWD_EN != 0) ? (haz_ex && ex_q.memtoreg)
                                   : (haz_ex || haz_mem || ((RF_BYPASS == 0) && haz_wb));
  assign stall     = id_valid && stall_raw;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    if (rst) begin
      ex_d  = SB_BUBBLE;
      mem_d = SB_BUBBLE;
      wb_d  = SB_BUBBLE;
    end else if (ext_hold) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_redirect) begin
      // The branch itself retires through WB; everything younger is squashed.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_evt   = 1'b1;
      ex_d        = SB_BUBBLE;
      mem_d       = SB_BUBBLE;
      wb_d        = mem_q;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_evt  = 1'b1;
      ex_d       = SB_BUBBLE;
      mem_d      = ex_q;
      wb_d       = mem_q;
    end else begin
      ex_d  = id_e;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
      wb_q  <= SB_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // MEM wins over WB because it holds the younger value; a load in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (is_writer(mem_q) && !mem_q.memtoreg && (mem_q.rd == src)) sel = FWD_MEM;
      else if (is_writer(wb_q) && (wb_q.rd == src))                  sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if ((FWD_EN != 0) && !rst && ex_q.valid) begin
      fwd_a = fwd_sel(ex_q.use_rs1, ex_q.rs1);
      fwd_b = fwd_sel(ex_q.use_rs2, ex_q.rs2);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_evt),
    .hold  (ext_hold),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt),
    .hold  (ext_hold),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a forwarding instance and a stall-only instance with
// narrow counters, both checked every cycle against an instruction-level pipeline model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memtoreg;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       mem_redirect, ext_hold;

  logic       pc_en_a, ifid_en_a, ifid_flush_a, idex_flush_a, exmem_flush_a;
  logic       idex_en_a, exmem_en_a, memwb_en_a;
  logic [1:0] fwd_a_a, fwd_b_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;

  logic       pc_en_b, ifid_en_b, ifid_flush_b, idex_flush_b, exmem_flush_b;
  logic       idex_en_b, exmem_en_b, memwb_en_b;
  logic [1:0] fwd_a_b, fwd_b_b;
  logic [3:0] stall_cnt_b, flush_cnt_b;

  pipeline_hazard_ctrl #(.FWD_EN(1), .RF_BYPASS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .mem_redirect(mem_redirect), .ext_hold(ext_hold),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .exmem_flush(exmem_flush_a), .idex_en(idex_en_a),
    .exmem_en(exmem_en_a), .memwb_en(memwb_en_a), .fwd_a(fwd_a_a), .fwd_b(fwd_b_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.FWD_EN(0), .RF_BYPASS(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .mem_redirect(mem_redirect), .ext_hold(ext_hold),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .exmem_flush(exmem_flush_b), .idex_en(idex_en_b),
    .exmem_en(exmem_en_b), .memwb_en(memwb_en_b), .fwd_a(fwd_a_b), .fwd_b(fwd_b_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit valid;
    int rd, rs1, rs2;
    bit u1, u2, rw, ld;
  } ins_t;

  ins_t pipe [2][3];           // [instance][0=EX,1=MEM,2=WB]
  int   scnt [2];
  int   fcnt [2];
  bit   cfg_fwd [2] = '{1'b1, 1'b0};
  int   cmax [2]    = '{65535, 15};
  bit   model_ok    = 1'b0;
  logic [11:0] exp_q[$];

  function automatic ins_t bubble();
    ins_t b;
    b = '{valid: 1'b0, rd: 0, rs1: 0, rs2: 0, u1: 1'b0, u2: 1'b0, rw: 1'b0, ld: 1'b0};
    return b;
  endfunction

  function automatic ins_t id_now();
    ins_t i;
    i = '{valid: id_valid, rd: int'(id_rd), rs1: int'(id_rs1), rs2: int'(id_rs2),
          u1: id_use_rs1, u2: id_use_rs2, rw: id_regwrite, ld: id_memtoreg};
    return i;
  endfunction

  function automatic bit writes(input ins_t i);
    return i.valid && i.rw && (i.rd != 0);
  endfunction

  function automatic bit id_reads(input int r);
    return (id_use_rs1 && int'(id_rs1) == r) || (id_use_rs2 && int'(id_rs2) == r);
  endfunction

  // A producer d stages ahead of ID blocks it when its value cannot reach EX in time.
  function automatic bit hazard(input int k);
    bit h;
    h = 1'b0;
    if (!id_valid) return 1'b0;
    if (cfg_fwd[k]) begin
      h = writes(pipe[k][0]) && pipe[k][0].ld && id_reads(pipe[k][0].rd);
    end else begin
      for (int s = 0; s < 2; s++)
        if (writes(pipe[k][s]) && id_reads(pipe[k][s].rd)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [1:0] fwd_calc(input int k, input bit second);
    ins_t ex, mem, wb;
    int   src;
    bit   used;
    ex = pipe[k][0]; mem = pipe[k][1]; wb = pipe[k][2];
    src  = second ? ex.rs2 : ex.rs1;
    used = second ? ex.u2  : ex.u1;
    if (rst || !cfg_fwd[k] || !ex.valid || !used) return 2'b00;
    if (writes(mem) && !mem.ld && mem.rd == src) return 2'b10;
    if (writes(wb) && wb.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, fwd_a, fwd_b}
  function automatic logic [11:0] exp_vec(input int k);
    logic [7:0] ctl;
    if (rst)               ctl = 8'b11111_000;
    else if (ext_hold)     ctl = 8'b00000_000;
    else if (mem_redirect) ctl = 8'b11111_111;
    else if (hazard(k))    ctl = 8'b00111_010;
    else                   ctl = 8'b11111_000;
    return {ctl, fwd_calc(k, 1'b0), fwd_calc(k, 1'b1)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 3; s++) pipe[k][s] = bubble();
        scnt[k] = 0;
        fcnt[k] = 0;
      end
    end else if (model_ok && !ext_hold) begin
      for (int k = 0; k < 2; k++) begin
        bit h;
        h = hazard(k);
        pipe[k][2] = pipe[k][1];
        if (mem_redirect) begin
          pipe[k][1] = bubble();
          pipe[k][0] = bubble();
          if (fcnt[k] < cmax[k]) fcnt[k]++;
        end else if (h) begin
          pipe[k][1] = pipe[k][0];
          pipe[k][0] = bubble();
          if (scnt[k] < cmax[k]) scnt[k]++;
        end else begin
          pipe[k][1] = pipe[k][0];
          pipe[k][0] = id_now();
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      exp_q.push_back(exp_vec(0));
      exp_q.push_back(exp_vec(1));
      chk("ctl_a", {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a,
                    ifid_flush_a, idex_flush_a, exmem_flush_a, fwd_a_a, fwd_b_a},
          32'(exp_q.pop_front()));
      chk("ctl_b", {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b,
                    ifid_flush_b, idex_flush_b, exmem_flush_b, fwd_a_b, fwd_b_b},
          32'(exp_q.pop_front()));
      chk("stall_cnt_a", 32'(stall_cnt_a), 32'(scnt[0]));
      chk("flush_cnt_a", 32'(flush_cnt_a), 32'(fcnt[0]));
      chk("stall_cnt_b", 32'(stall_cnt_b), 32'(scnt[1]));
      chk("flush_cnt_b", 32'(flush_cnt_b), 32'(fcnt[1]));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit ld);
    id_valid    = v;
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_memtoreg = ld;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_redirect = 1'b0;
    ext_hold = 1'b0;
    nop();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_redirect = 1'b0;
    ext_hold = 1'b0;
    nop();
    do_reset();
    mid();
    chk("reset_pc_en", pc_en_a, 1);
    chk("reset_fwd", {fwd_a_a, fwd_b_a}, 0);
    chk("reset_cnt", stall_cnt_a, 0);

    // Load-use with forwarding: one bubble, then WB forward.
    step();
    drive(1, 1, 0, 1, 0, 5, 1, 1);          // LW x5
    step();
    drive(1, 5, 7, 1, 1, 6, 1, 0);          // ADD x6,x5,x7
    mid();
    chk("lu_pc_en", pc_en_a, 0);
    chk("lu_idex_flush", idex_flush_a, 1);
    step();
    mid();
    chk("lu_stall_cnt", stall_cnt_a, 1);
    chk("lu_resume", pc_en_a, 1);
    step();
    nop();
    mid();
    chk("lu_fwd_a", fwd_a_a, 2'b01);
    chk("lu_fwd_b", fwd_b_a, 2'b00);

    // Back-to-back ALU dependency forwards from MEM; one apart forwards from WB.
    do_reset();
    drive(1, 0, 0, 1, 0, 3, 1, 0);          // ADDI x3,x0,4
    step();
    drive(1, 3, 3, 1, 1, 4, 1, 0);          // ADD x4,x3,x3
    step();
    nop();
    mid();
    chk("mem_fwd", {fwd_a_a, fwd_b_a}, 4'b1010);
    chk("alu_no_stall", stall_cnt_a, 0);
    step();
    drive(1, 0, 0, 1, 0, 3, 1, 0);
    step();
    drive(1, 0, 0, 1, 0, 9, 1, 0);          // independent ADDI x9
    step();
    drive(1, 3, 3, 1, 1, 4, 1, 0);
    step();
    nop();
    mid();
    chk("wb_fwd", {fwd_a_a, fwd_b_a}, 4'b0101);

    // Writes to x0 never stall or forward, even from a load.
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 1, 1);          // LW x0
    step();
    drive(1, 0, 0, 1, 1, 10, 1, 0);         // ADD x10,x0,x0
    mid();
    chk("x0_no_stall", pc_en_a, 1);
    step();
    nop();
    mid();
    chk("x0_fwd", {fwd_a_a, fwd_b_a}, 0);

    // Redirect beats a coincident load-use stall.
    do_reset();
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    step();
    drive(1, 5, 7, 1, 1, 6, 1, 0);
    mem_redirect = 1'b1;
    mid();
    chk("redir_flushes", {ifid_flush_a, idex_flush_a, exmem_flush_a}, 3'b111);
    chk("redir_pc_en", pc_en_a, 1);
    step();
    mem_redirect = 1'b0;
    mid();
    chk("redir_flush_cnt", flush_cnt_a, 1);
    chk("redir_stall_cnt", stall_cnt_a, 0);
    chk("redir_ex_empty", pc_en_a, 1);

    // Hold masks a pending redirect until it drops.
    do_reset();
    ext_hold = 1'b1;
    mem_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("hold_en", {pc_en_a, ifid_en_a, memwb_en_a}, 0);
      chk("hold_flush", ifid_flush_a, 0);
      step();
    end
    ext_hold = 1'b0;
    mid();
    chk("hold_release_flush", ifid_flush_a, 1);
    step();
    mem_redirect = 1'b0;
    mid();
    chk("hold_flush_cnt", flush_cnt_a, 1);

    // No forwarding: a dependent ALU op waits two cycles for the bypassing regfile.
    do_reset();
    drive(1, 0, 0, 1, 0, 2, 1, 0);          // ADDI x2
    step();
    drive(1, 2, 2, 1, 1, 8, 1, 0);          // ADD x8,x2,x2
    mid();
    chk("nofwd_stall1", pc_en_b, 0);
    step();
    mid();
    chk("nofwd_stall2", pc_en_b, 0);
    step();
    mid();
    chk("nofwd_go", pc_en_b, 1);
    chk("nofwd_cnt", stall_cnt_b, 2);

    // 16 stalls into a 4-bit counter must stick at 15.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      drive(1, 0, 0, 1, 0, 2, 1, 0);
      step();
      drive(1, 2, 2, 1, 1, 8, 1, 0);
      step();
      step();
      step();
    end
    nop();
    mid();
    chk("sat_cnt", stall_cnt_b, 4'hf);

    // Reset in the middle of a stall.
    do_reset();
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    step();
    drive(1, 5, 7, 1, 1, 6, 1, 0);
    mid();
    chk("rst_pre_stall", pc_en_a, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mid();
    chk("rst_clears_ex", pc_en_a, 1);
    chk("rst_cnt", stall_cnt_a, 0);

    // Random traffic over a small register set to provoke many hazards.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(99) < 85, $urandom_range(3), $urandom_range(3),
            $urandom_range(1), $urandom_range(1), $urandom_range(3),
            $urandom_range(1), $urandom_range(2) == 0);
      mem_redirect = ($urandom_range(11) == 0);
      ext_hold     = ($urandom_range(9) == 0);
      rst          = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    ext_hold = 1'b0;
    mem_redirect = 1'b0;
    nop();
    step();
    mid();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB) around the control unit's decoded outputs.
- Keeps a shadow scoreboard of in-flight destination registers.
- Generates load-use stalls, branch/jump flushes in the MEM stage, and EX-stage operand forwarding selects.
- Sits beside the decoder in ID and drives the PC and pipeline-register enables and flushes. Includes saturating stall and flush performance counters.

Parameters:
- FWD_EN, 1, 1 = forwarding network present; 0 = resolve every RAW hazard by stalling.
- RF_BYPASS, 1, 1 = register file is write-before-read, so a WB-stage producer is no hazard.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  source registers of the ID instruction
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2 (R-type: both; I-type/LW: rs1; SW/branch: both; JAL: none)
- id_rd  in  5  destination register
- id_regwrite  in  1  CU RegWrite
- id_memtoreg  in  1  CU MemtoReg (load)
- mem_redirect  in  1  branch taken or jump, resolved in MEM
- ext_hold  in  1  data-memory wait; freezes the whole pipe
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that register
- idex_en, exmem_en, memwb_en  out  1 each  register enables
- fwd_a, fwd_b  out  2 each  EX operand select: 00 = regfile, 01 = WB result, 10 = MEM ALU result
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Scoreboard: three entries EX, MEM, WB. Each entry holds {valid, rd, regwrite, memtoreg}; the EX entry also holds {rs1, rs2, use_rs1, use_rs2}.
- A "writer" is an entry with valid && regwrite && rd != 0. Register x0 never creates a hazard or a forward.
- Priority, highest first: rst > ext_hold > mem_redirect > stall > run.
- rst:
  - All entries invalid; counters 0.
  - Outputs combinational from scoreboard state, so during and after reset: pc_en = ifid_en = idex_en = exmem_en = memwb_en = 1, all flushes 0, fwd 00.
- ext_hold = 1:
  - All enables 0, all flushes 0, scoreboard and counters frozen.
  - A mem_redirect present during hold takes effect in the first cycle with hold = 0.
- mem_redirect (hold = 0):
  - ifid_flush = idex_flush = exmem_flush = 1 and all enables 1. The PC loads the target from the datapath.
  - Next cycle: EX <= bubble, MEM <= bubble, WB <= old MEM (the branch itself).
  - Any simultaneous stall is suppressed.
  - flush_cnt += 1.
- Stall (no hold, no redirect):
  - FWD_EN = 1: stall when the EX entry is a writer with memtoreg = 1 and its rd matches an in-use ID source.
  - FWD_EN = 0: stall when EX or MEM is a writer matching an in-use ID source. WB is also checked when RF_BYPASS = 0.
  - Only when id_valid = 1.
  - On stall: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = memwb_en = 1.
  - Next: EX <= bubble, MEM <= old EX, WB <= old MEM.
  - stall_cnt += 1 per stalled cycle.
- Run: all enables 1, no flush. EX <= ID fields (valid = id_valid), MEM <= EX, WB <= MEM.
- Forwarding (combinational from the EX entry):
  - fwd_a = 10 if MEM is a writer, non-load, with rd == EX.rs1 && EX.use_rs1.
  - Else 01 if WB is a writer with rd == EX.rs1.
  - Else 00.
  - fwd_b is the same using rs2.
  - MEM has priority over WB. A load in MEM is never forwarded from MEM (the stall guarantees it is in WB).
  - FWD_EN = 0 forces fwd 00.
- Counters saturate at all-ones and never wrap.
- Latency: load-use costs 1 bubble; redirect costs 3 bubbles.

Decomposition:
- Shared package pipe_pkg:
  - FWD_RF / FWD_WB / FWD_MEM encodings.
  - Scoreboard entry struct.
  - REG_W = 5.
  - Opcode constants (LW 00000, SW 01000, ADDI 00100, RTYPE 01100, BRANCH 11000, JAL 11011), shared with ControlUnit.
- One natural sub-module: sat_counter (parameter width, inc, hold, rst), instantiated twice.

Test Plan:
- LW x5 then ADD x6,x5,x7 (FWD_EN = 1) -> exactly one cycle pc_en = 0, idex_flush = 1, stall_cnt = 1. Next cycle ADD in EX with fwd_a = 01.
- ADDI x3,x0,4 then ADD x4,x3,x3 -> no stall, fwd_a = fwd_b = 10. One more independent instruction between them -> fwd = 01.
- Writer with rd = x0 followed by a reader of x0 -> no stall, fwd 00.
- mem_redirect = 1 coincident with a load-use condition in ID -> three flushes, no stall, flush_cnt = 1, stall_cnt unchanged. Following cycle EX and MEM entries are invalid.
- ext_hold = 1 for 3 cycles with mem_redirect = 1 -> all enables 0, no flush. Flush occurs in the cycle hold drops.
- FWD_EN = 0, RF_BYPASS = 1: ADDI x2 then ADD x8,x2,x2 -> 2 stall cycles, then proceeds. Force stall_cnt to 0xFFFF -> stays 0xFFFF on the next stall.
- rst asserted mid-stall -> next cycle all entries invalid, enables 1, counters 0.
